// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the IFU/LSU memory port arbiter
package mem_arb_pkg;
  localparam int WAIT_CNT_W = 4;
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int SEL_W = 4;
  typedef enum logic [1:0] {RSP_NONE, RSP_IFU, RSP_LSU} rsp_owner_e;
endpackage

// File: rtl/arb_wait_cnt.sv
// arb_wait_cnt: saturating count of consecutive IFU-denied cycles
module arb_wait_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  assign at_max_o = cnt_q == WAIT_CNT_W'(MAX);
  always_comb cnt_d = clr_i ? '0 : (inc_i && !at_max_o) ? cnt_q + WAIT_CNT_W'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync-read RAM between IFU and LSU, LSU priority with IFU starvation guard
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ifu_req_i,
  input  logic [AW-1:0]    ifu_addr_i,
  output logic             ifu_gnt_o,
  output logic             ifu_rvalid_o,
  output logic [DW-1:0]    ifu_rdata_o,
  input  logic             lsu_req_i,
  input  logic             lsu_we_i,
  input  logic [SEL_W-1:0] lsu_sel_i,
  input  logic [AW-1:0]    lsu_addr_i,
  input  logic [DW-1:0]    lsu_wdata_i,
  output logic             lsu_gnt_o,
  output logic             lsu_rvalid_o,
  output logic [DW-1:0]    lsu_rdata_o,
  output logic             mem_ce_o,
  output logic             mem_we_o,
  output logic [SEL_W-1:0] mem_sel_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i
);
  rsp_owner_e rsp_q, rsp_d;
  logic ifu_starved;
  arb_wait_cnt #(.MAX(MAX_WAIT)) u_wait_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (ifu_req_i && !ifu_gnt_o),
    .clr_i   (!ifu_req_i || ifu_gnt_o),
    .at_max_o(ifu_starved)
  );
  assign ifu_gnt_o = ifu_req_i && (!lsu_req_i || ifu_starved);
  assign lsu_gnt_o = lsu_req_i && !ifu_gnt_o;
  always_comb begin
    mem_ce_o    = ifu_gnt_o || lsu_gnt_o;
    mem_we_o    = lsu_gnt_o && lsu_we_i;
    mem_sel_o   = ifu_gnt_o ? '1 : lsu_gnt_o ? (lsu_we_i ? lsu_sel_i : '1) : '0;
    mem_addr_o  = ifu_gnt_o ? ifu_addr_i : lsu_gnt_o ? lsu_addr_i : '0;
    mem_wdata_o = lsu_gnt_o ? lsu_wdata_i : '0;
    rsp_d       = ifu_gnt_o ? RSP_IFU : (lsu_gnt_o && !lsu_we_i) ? RSP_LSU : RSP_NONE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rsp_q <= RSP_NONE;
    else rsp_q <= rsp_d;
  assign ifu_rvalid_o = rsp_q == RSP_IFU;
  assign lsu_rvalid_o = rsp_q == RSP_LSU;
  assign ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
  assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, corner sequences and random traffic against a reference model
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic ifu_req_i = 1'b0, lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [31:0] ifu_addr_i = '0, lsu_addr_i = '0, lsu_wdata_i = '0, mem_rdata_i = '0;
  logic [3:0] lsu_sel_i = '0;
  logic ifu_gnt_o, ifu_rvalid_o, lsu_gnt_o, lsu_rvalid_o, mem_ce_o, mem_we_o;
  logic [31:0] ifu_rdata_o, lsu_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_sel_o;
  always #5 clk_i = ~clk_i;
  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_sel_i(lsu_sel_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'h00000013;
      1: return 32'h00100093;
      2: return 32'h00200113;
      4: return 32'h11223344;
      default: return 32'(i) * 32'h9E3779B1;
    endcase
  endfunction

  // Memory macro: byte-enabled write, registered read
  logic [31:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk_i);
      if (mem_ce_o) begin
        if (mem_we_o) begin
          for (int b = 0; b < 4; b++) if (mem_sel_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end else mem_rdata_i <= ram[mem_addr_o[9:2]];
      end
    end
  end

  int checks = 0, failures = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // Reference model: denied-cycle count, pending response owner/data, expected memory image
  logic [31:0] ref_mem [256];
  int denied = 0, pend = 0;
  logic [31:0] pend_d = '0;
  logic mdl_gi, mdl_gl, obs_ig, obs_lg, obs_iv, obs_lv;
  logic [31:0] obs_rd;

  task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                      input logic [3:0] ls, input logic [31:0] la, input logic [31:0] ld);
    ifu_req_i = ir; ifu_addr_i = ia; lsu_req_i = lr; lsu_we_i = lw;
    lsu_sel_i = ls; lsu_addr_i = la; lsu_wdata_i = ld;
    #1;
    mdl_gi = ir && (!lr || denied >= MAX_WAIT);
    mdl_gl = lr && !mdl_gi;
    obs_ig = ifu_gnt_o; obs_lg = lsu_gnt_o; obs_iv = ifu_rvalid_o; obs_lv = lsu_rvalid_o;
    obs_rd = ifu_rdata_o | lsu_rdata_o;
    chk("ifu_gnt", ifu_gnt_o, mdl_gi);
    chk("lsu_gnt", lsu_gnt_o, mdl_gl);
    chk("mem_ctrl", {mem_ce_o, mem_we_o, mem_sel_o},
        {mdl_gi || mdl_gl, mdl_gl && lw, mdl_gi ? 4'hF : mdl_gl ? (lw ? ls : 4'hF) : 4'h0});
    chk("mem_addr", mem_addr_o, mdl_gi ? ia : mdl_gl ? la : 32'h0);
    if (mdl_gl && lw) chk("mem_wdata", mem_wdata_o, ld);
    else if (!mdl_gi && !mdl_gl) chk("mem_wdata_idle", mem_wdata_o, 0);
    chk("ifu_rvalid", ifu_rvalid_o, pend == 1);
    chk("ifu_rdata", ifu_rdata_o, pend == 1 ? pend_d : 32'h0);
    chk("lsu_rvalid", lsu_rvalid_o, pend == 2);
    chk("lsu_rdata", lsu_rdata_o, pend == 2 ? pend_d : 32'h0);
    pend = 0;
    if (mdl_gi) begin pend = 1; pend_d = ref_mem[ia[9:2]]; end
    else if (mdl_gl && !lw) begin pend = 2; pend_d = ref_mem[la[9:2]]; end
    else if (mdl_gl) for (int b = 0; b < 4; b++) if (ls[b]) ref_mem[la[9:2]][8*b +: 8] = ld[8*b +: 8];
    denied = (ir && !mdl_gi) ? denied + 1 : 0;
    @(negedge clk_i);
  endtask

  typedef struct {
    logic ir; logic [31:0] ia; logic lr, lw; logic [3:0] ls; logic [31:0] la, ld;
    logic ig, lg, iv, lv; logic [31:0] rd;
  } vec_t;
  vec_t tbl [8];

  logic hi = 1'b0, hl = 1'b0, rl_w = 1'b0;
  logic [31:0] ra = '0, rl_a = '0, rl_d = '0;
  logic [3:0] rl_s = '0;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    tbl[0] = '{1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h00000013};
    tbl[2] = '{1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h00100093};
    tbl[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h00200113};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h10, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h1122CCDD};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_rvalid", {ifu_rvalid_o, lsu_rvalid_o}, 2'b00);
    chk("reset_rdata", {ifu_rdata_o, lsu_rdata_o}, 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].ir, tbl[i].ia, tbl[i].lr, tbl[i].lw, tbl[i].ls, tbl[i].la, tbl[i].ld);
      chk($sformatf("vec%0d_gnt", i), {obs_ig, obs_lg}, {tbl[i].ig, tbl[i].lg});
      chk($sformatf("vec%0d_rvalid", i), {obs_iv, obs_lv}, {tbl[i].iv, tbl[i].lv});
      chk($sformatf("vec%0d_rdata", i), obs_rd, tbl[i].rd);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h100 + 32'(i) * 4, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      chk("starve_ifu_gnt", obs_ig, (i % 5) == 4);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    rst_ni = 1'b0;
    ifu_req_i = 1'b0; lsu_req_i = 1'b0;
    #1;
    chk("rst_drop_rvalid", lsu_rvalid_o, 1'b0);
    chk("rst_drop_rdata", lsu_rdata_o, 32'h0);
    pend = 0; denied = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst_ifu_first", obs_ig, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h44, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      chk("rst_cnt_cleared", obs_ig, i == 4);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 32'h80, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h84, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
      chk("withdraw_restart", obs_ig, i == 4);
    end
    for (int n = 0; n < 400; n++) begin
      if (!hi && $urandom_range(0, 2) != 0) begin
        hi = 1'b1; ra = 32'($urandom_range(0, 63)) << 2;
      end
      if (!hl && $urandom_range(0, 1) != 0) begin
        hl = 1'b1; rl_w = 1'($urandom_range(0, 1)); rl_s = 4'($urandom);
        rl_a = 32'($urandom_range(0, 63)) << 2; rl_d = $urandom;
      end
      step(hi, ra, hl, rl_w, rl_s, rl_a, rl_d);
      if (mdl_gi || (hi && $urandom_range(0, 7) == 0)) hi = 1'b0;
      if (mdl_gl) hl = 1'b0;
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
